// File: rtl/cond_writeback_unit_if.sv
// Bus between the ALU/decode stage and the conditional writeback unit.
// The unit takes the slave modport; the upstream driver takes master.
interface cond_writeback_unit_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
);
  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS;
  logic          RegW;
  logic          MemW;
  logic          NoWrite;
  logic          LongMul;
  logic [DW-1:0] Result;
  logic [DW-1:0] ResultExtra;
  logic [RW-1:0] RdLo;
  logic [RW-1:0] RdHi;

  logic          PCSrc;
  logic          RegWrite;
  logic          MemWrite;
  logic [RW-1:0] WA3;
  logic [DW-1:0] WD3;
  logic          Stall;
  logic [3:0]    Flags;
  logic          CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, LongMul,
    output Result, ResultExtra, RdLo, RdHi,
    input  PCSrc, RegWrite, MemWrite, WA3, WD3, Stall, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, LongMul,
    input  Result, ResultExtra, RdLo, RdHi,
    output PCSrc, RegWrite, MemWrite, WA3, WD3, Stall, Flags, CondEx
  );
endinterface

// File: rtl/cond_writeback_unit.sv
// Holds NZCV, evaluates the ARM condition field and gates PC/register/memory writes;
// long multiplies are written back over two beats (low word, then high word).
module cond_writeback_unit #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input logic                 clk,
  input logic                 reset,
  cond_writeback_unit_if.slave bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StHi   = 1'b1;

  logic          state_q, state_d;
  logic [3:0]    flags_q, flags_d;
  logic [RW-1:0] hi_addr_q, hi_addr_d;
  logic [DW-1:0] hi_data_q, hi_data_d;

  logic n, z, c, v;
  logic cond_ex;
  logic launch;

  assign {n, z, c, v} = flags_q;

  // Condition is judged against the flags as they stood before this cycle.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign launch = bus.LongMul & bus.RegW & cond_ex & ~bus.NoWrite;

  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    hi_addr_d    = hi_addr_q;
    hi_data_d    = hi_data_q;
    bus.PCSrc    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Stall    = 1'b0;
    bus.WA3      = bus.RdLo;
    bus.WD3      = bus.Result;

    if (state_q == StHi) begin
      // Second beat: inputs are ignored, the held high word goes out.
      bus.RegWrite = 1'b1;
      bus.WA3      = hi_addr_q;
      bus.WD3      = hi_data_q;
      state_d      = StIdle;
    end else begin
      if (cond_ex) begin
        if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
        if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
      end
      if (launch) begin
        bus.RegWrite = 1'b1;
        bus.Stall    = 1'b1;
        hi_addr_d    = bus.RdHi;
        hi_data_d    = bus.ResultExtra;
        state_d      = StHi;
      end else begin
        bus.PCSrc    = bus.PCS & cond_ex;
        bus.MemWrite = bus.MemW & cond_ex;
        bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
      end
    end

    // Reset kills any in-flight high-word write as well as the enables.
    if (reset) begin
      bus.PCSrc    = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
      bus.Stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      flags_q   <= 4'b0000;
      hi_addr_q <= '0;
      hi_data_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
    end
  end

  assign bus.Flags  = flags_q;
  assign bus.CondEx = cond_ex;

endmodule

// File: tb/tb_cond_writeback_unit.sv
// Scoreboard bench for cond_writeback_unit: a reference model pushes expected outputs
// per cycle, which are popped and compared at the following falling edge.
module tb_cond_writeback_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cond_writeback_unit_if #(.DW(32), .RW(4)) bus ();

  cond_writeback_unit #(.DW(32), .RW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        pcsrc;
    logic        regwrite;
    logic        memwrite;
    logic        stall;
    logic        condex;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic [3:0]  flags;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  m_flags   = 4'h0;
  logic        m_hi      = 1'b0;
  logic [3:0]  m_hi_addr = 4'h0;
  logic [31:0] m_hi_data = 32'h0;
  logic        prev_stall = 1'b0;

  logic        o_pcsrc, o_regwrite, o_memwrite, o_stall, o_condex;
  logic [3:0]  o_wa3, o_flags;
  logic [31:0] o_wd3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic cond_pass(input logic [3:0] cnd, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cnd)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: predict, push, sample at negedge, pop/compare, advance model.
  task automatic step();
    exp_t e;
    logic cp, launch;
    cp     = cond_pass(bus.Cond, m_flags);
    launch = !m_hi && bus.LongMul && bus.RegW && cp && !bus.NoWrite;
    e        = '0;
    e.rst    = reset;
    e.condex = cp;
    e.flags  = m_flags;
    e.wa3    = bus.RdLo;
    e.wd3    = bus.Result;
    if (reset) begin
      e.regwrite = 1'b0;
    end else if (m_hi) begin
      e.regwrite = 1'b1;
      e.wa3      = m_hi_addr;
      e.wd3      = m_hi_data;
    end else if (launch) begin
      e.regwrite = 1'b1;
      e.stall    = 1'b1;
    end else begin
      e.pcsrc    = bus.PCS & cp;
      e.memwrite = bus.MemW & cp;
      e.regwrite = bus.RegW & cp & !bus.NoWrite;
    end
    exp_q.push_back(e);

    @(negedge clk);
    o_pcsrc = bus.PCSrc;  o_regwrite = bus.RegWrite; o_memwrite = bus.MemWrite;
    o_stall = bus.Stall;  o_condex   = bus.CondEx;   o_flags    = bus.Flags;
    o_wa3   = bus.WA3;    o_wd3      = bus.WD3;

    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("pcsrc", {31'd0, o_pcsrc}, {31'd0, e.pcsrc});
      check_eq("regwrite", {31'd0, o_regwrite}, {31'd0, e.regwrite});
      check_eq("memwrite", {31'd0, o_memwrite}, {31'd0, e.memwrite});
      check_eq("stall", {31'd0, o_stall}, {31'd0, e.stall});
      check_eq("stall_twice", {31'd0, o_stall & prev_stall}, 32'd0);
      if (!e.rst) begin
        check_eq("condex", {31'd0, o_condex}, {31'd0, e.condex});
        check_eq("flags", {28'd0, o_flags}, {28'd0, e.flags});
      end
      if (e.regwrite) begin
        check_eq("wa3", {28'd0, o_wa3}, {28'd0, e.wa3});
        check_eq("wd3", o_wd3, e.wd3);
      end
    end
    prev_stall = o_stall;

    if (reset) begin
      m_flags = 4'h0; m_hi = 1'b0; m_hi_addr = 4'h0; m_hi_data = 32'h0;
    end else if (m_hi) begin
      m_hi = 1'b0;
    end else begin
      if (cp && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (cp && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
      if (launch) begin
        m_hi = 1'b1; m_hi_addr = bus.RdHi; m_hi_data = bus.ResultExtra;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ctl = {PCS, RegW, MemW, NoWrite, LongMul}
  task automatic op(input logic [3:0] cnd, input logic [3:0] aluf, input logic [1:0] flagw,
                    input logic [4:0] ctl, input logic [31:0] res = 32'h0,
                    input logic [31:0] resx = 32'h0, input logic [3:0] rdlo = 4'h0,
                    input logic [3:0] rdhi = 4'h0);
    bus.Cond = cnd;  bus.ALUFlags = aluf;  bus.FlagW = flagw;
    {bus.PCS, bus.RegW, bus.MemW, bus.NoWrite, bus.LongMul} = ctl;
    bus.Result = res;  bus.ResultExtra = resx;  bus.RdLo = rdlo;  bus.RdHi = rdhi;
    step();
  endtask

  initial begin
    op(4'h0, 4'h0, 2'b00, 5'b0);
    op(4'h0, 4'h0, 2'b00, 5'b0);
    reset = 1'b0;

    // Cold flags: EQ fails, then AL loads Z and EQ passes.
    op(4'h0, 4'h0, 2'b00, 5'b0);
    check_eq("eq_after_reset", {31'd0, o_condex}, 32'd0);
    op(4'hE, 4'b0100, 2'b11, 5'b0);
    op(4'h0, 4'h0, 2'b00, 5'b0);
    check_eq("eq_after_z", {31'd0, o_condex}, 32'd1);
    check_eq("flags_z", {28'd0, o_flags}, 32'h4);

    // Signed compares with N=1, V=1.
    op(4'hE, 4'b1001, 2'b11, 5'b0);
    op(4'hA, 4'h0, 2'b00, 5'b0);  check_eq("ge", {31'd0, o_condex}, 32'd1);
    op(4'hB, 4'h0, 2'b00, 5'b0);  check_eq("lt", {31'd0, o_condex}, 32'd0);
    op(4'hC, 4'h0, 2'b00, 5'b0);  check_eq("gt", {31'd0, o_condex}, 32'd1);
    op(4'hD, 4'h0, 2'b00, 5'b0);  check_eq("le", {31'd0, o_condex}, 32'd0);

    for (int f = 0; f < 16; f++) begin
      op(4'hE, 4'(f), 2'b11, 5'b0);
      op(4'hF, 4'h0, 2'b00, 5'b11100);
      check_eq("never", {31'd0, o_condex}, 32'd0);
      check_eq("never_regwrite", {31'd0, o_regwrite}, 32'd0);
    end

    // Write gating.
    op(4'hE, 4'h0, 2'b11, 5'b0);
    op(4'h1, 4'h0, 2'b00, 5'b11100, 32'h55, 32'h0, 4'h2);
    check_eq("ne_enables", {29'd0, o_pcsrc, o_regwrite, o_memwrite}, 32'h7);
    op(4'h0, 4'h0, 2'b00, 5'b11100);
    check_eq("eq_enables", {29'd0, o_pcsrc, o_regwrite, o_memwrite}, 32'h0);
    op(4'hE, 4'b0010, 2'b11, 5'b01010);
    check_eq("nowrite", {31'd0, o_regwrite}, 32'd0);
    op(4'h0, 4'h0, 2'b00, 5'b0);
    check_eq("nowrite_flags", {28'd0, o_flags}, 32'h2);

    // UMULL, two beats.
    op(4'hE, 4'h0, 2'b00, 5'b01001, 32'h1, 32'hFFFF_FFFE, 4'd4, 4'd5);
    check_eq("umull_lo_we", {31'd0, o_regwrite}, 32'd1);
    check_eq("umull_lo_wa3", {28'd0, o_wa3}, 32'd4);
    check_eq("umull_lo_wd3", o_wd3, 32'h1);
    check_eq("umull_lo_stall", {31'd0, o_stall}, 32'd1);
    op(4'hE, 4'h0, 2'b00, 5'b01001, 32'h1, 32'hFFFF_FFFE, 4'd4, 4'd5);
    check_eq("umull_hi_wa3", {28'd0, o_wa3}, 32'd5);
    check_eq("umull_hi_wd3", o_wd3, 32'hFFFF_FFFE);
    check_eq("umull_hi_stall", {31'd0, o_stall}, 32'd0);
    op(4'hE, 4'h0, 2'b00, 5'b0);
    check_eq("umull_idle", {30'd0, o_regwrite, o_stall}, 32'd0);

    // Failed long multiply (Z=0).
    op(4'h0, 4'h0, 2'b11, 5'b01001, 32'h9, 32'h9, 4'd1, 4'd2);
    check_eq("lm_fail", {30'd0, o_regwrite, o_stall}, 32'd0);

    // Reset during the high beat.
    op(4'hE, 4'hF, 2'b11, 5'b01001, 32'h3, 32'h4, 4'd6, 4'd7);
    reset = 1'b1;
    op(4'hE, 4'h0, 2'b00, 5'b0);
    check_eq("rst_hi_regwrite", {31'd0, o_regwrite}, 32'd0);
    reset = 1'b0;
    op(4'h0, 4'h0, 2'b00, 5'b0);
    check_eq("rst_hi_flags", {28'd0, o_flags}, 32'h0);
    op(4'hE, 4'h0, 2'b00, 5'b01000, 32'h7, 32'h0, 4'd3);
    check_eq("rst_hi_idle_wa3", {28'd0, o_wa3}, 32'd3);
    check_eq("rst_hi_idle_stall", {31'd0, o_stall}, 32'd0);

    // Partial flag writes.
    op(4'hE, 4'hF, 2'b11, 5'b0);
    op(4'hE, 4'h0, 2'b01, 5'b0);
    op(4'hE, 4'h0, 2'b00, 5'b0);
    check_eq("flagw01", {28'd0, o_flags}, 32'hC);
    op(4'hE, 4'h0, 2'b10, 5'b0);
    op(4'hE, 4'h0, 2'b00, 5'b0);
    check_eq("flagw10", {28'd0, o_flags}, 32'h0);

    // Same destination for both words.
    op(4'hE, 4'h0, 2'b00, 5'b01001, 32'hAA, 32'hBB, 4'd9, 4'd9);
    op(4'hE, 4'h0, 2'b00, 5'b0);
    check_eq("same_rd_hi", o_wd3, 32'hBB);

    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 40) == 0);
      op(4'($urandom), 4'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom,
         4'($urandom), 4'($urandom));
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
